// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller for the 5-stage core. It tracks the
//            destination registers of the instructions in EX/MEM/WB with a
//            shadow pipeline. For the DE instruction it generates:
//              - stall and flush controls
//              - operand-forwarding selects
//            It also sequences the multi-cycle wrong-path flush that follows
//            a redirect resolved in EX.
// Ports    : clk, rst (sync, active-high)
//            de_*        : DE-stage instruction fields
//            ex_redirect : branch/jump redirect resolved in EX
//            mem_busy    : data memory stall, freezes the whole pipe
//            if_en, de_en       : stage enables
//            de_flush, ex_flush : flush controls
//            fwd_a, fwd_b       : forwarding selects
//                                 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB data
// Options  : `define HAZARD_PERF_EN adds 32-bit perf_stall / perf_flush
//            counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int         FLUSH_CYCLES = 2,      // 1..7
    parameter logic [1:0] WB_LOAD      = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_valid,
    input  logic [4:0]  de_rs1,
    input  logic [4:0]  de_rs2,
    input  logic        de_rs1_need,
    input  logic        de_rs2_need,
    input  logic [4:0]  de_rd,
    input  logic        de_reg_we,
    input  logic [1:0]  de_wb_ctr,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        if_en,
    output logic        de_en,
    output logic        de_flush,
    output logic        ex_flush,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
`endif
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);

    localparam logic [2:0] c_CNT_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;

    // Shadow pipeline entries {valid, rd, we, is_load}
    logic       r_ex_v, r_ex_we, r_ex_ld;
    logic [4:0] r_ex_rd;
    logic       r_mem_v, r_mem_we, r_mem_ld;
    logic [4:0] r_mem_rd;
    logic       r_wb_v, r_wb_we;
    logic [4:0] r_wb_rd;

    logic w_ex_m1, w_mem_m1, w_wb_m1;
    logic w_ex_m2, w_mem_m2, w_wb_m2;
    logic w_load_use;
    logic w_stall;

    function automatic logic f_match(input logic       v,
                                     input logic       we,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs,
                                     input logic       need,
                                     input logic       dv);
        return v & we & (rd != 5'd0) & (rd == rs) & need & dv;
    endfunction

    function automatic logic [1:0] f_fwd(input logic ex_m,
                                         input logic mem_m,
                                         input logic wb_m);
        if (ex_m)       return 2'b01;
        else if (mem_m) return 2'b10;
        else if (wb_m)  return 2'b11;
        else            return 2'b00;
    endfunction

    always_comb begin
        w_ex_m1  = f_match(r_ex_v,  r_ex_we,  r_ex_rd,  de_rs1, de_rs1_need, de_valid);
        w_mem_m1 = f_match(r_mem_v, r_mem_we, r_mem_rd, de_rs1, de_rs1_need, de_valid);
        w_wb_m1  = f_match(r_wb_v,  r_wb_we,  r_wb_rd,  de_rs1, de_rs1_need, de_valid);
        w_ex_m2  = f_match(r_ex_v,  r_ex_we,  r_ex_rd,  de_rs2, de_rs2_need, de_valid);
        w_mem_m2 = f_match(r_mem_v, r_mem_we, r_mem_rd, de_rs2, de_rs2_need, de_valid);
        w_wb_m2  = f_match(r_wb_v,  r_wb_we,  r_wb_rd,  de_rs2, de_rs2_need, de_valid);
        fwd_a    = f_fwd(w_ex_m1, w_mem_m1, w_wb_m1);
        fwd_b    = f_fwd(w_ex_m2, w_mem_m2, w_wb_m2);
        // A load in EX produces its data only in MEM, so a dependent DE
        // instruction must wait one cycle.
        w_load_use = r_ex_ld & (w_ex_m1 | w_ex_m2);
    end

    // Priority: mem_busy > redirect > load-use. DRAIN ignores both redirect
    // (EX holds a bubble) and load-use (DE is being flushed).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if_en       = 1'b1;
        de_en       = 1'b1;
        de_flush    = 1'b0;
        ex_flush    = 1'b0;
        w_stall     = 1'b0;
        if (mem_busy) begin
            if_en = 1'b0;
            de_en = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ex_redirect) begin
                        de_flush = 1'b1;
                        ex_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_state_nxt = ST_DRAIN;
                            w_cnt_nxt   = c_CNT_INIT;
                        end
                    end else if (w_load_use) begin
                        if_en    = 1'b0;
                        de_en    = 1'b0;
                        ex_flush = 1'b1;
                        w_stall  = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    de_flush = 1'b1;
                    if (r_cnt == 3'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Shadow pipeline advances only when the pipe is not frozen. An
    // instruction bubbled out of DE enters EX as invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_v   <= 1'b0;
            r_ex_we  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_ex_rd  <= 5'd0;
            r_mem_v  <= 1'b0;
            r_mem_we <= 1'b0;
            r_mem_ld <= 1'b0;
            r_mem_rd <= 5'd0;
            r_wb_v   <= 1'b0;
            r_wb_we  <= 1'b0;
            r_wb_rd  <= 5'd0;
        end else if (!mem_busy) begin
            r_wb_v   <= r_mem_v;
            r_wb_we  <= r_mem_we;
            r_wb_rd  <= r_mem_rd;
            r_mem_v  <= r_ex_v;
            r_mem_we <= r_ex_we;
            r_mem_ld <= r_ex_ld;
            r_mem_rd <= r_ex_rd;
            r_ex_v   <= de_valid & ~ex_flush;
            r_ex_we  <= de_reg_we;
            r_ex_ld  <= (de_wb_ctr == WB_LOAD);
            r_ex_rd  <= de_rd;
        end
    end

    // The load flag is not needed past MEM; reading it here keeps every
    // shadow bit observed.
    logic w_unused;
    assign w_unused = r_mem_ld;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall <= 32'd0;
            perf_flush <= 32'd0;
        end else begin
            if (w_stall)  perf_stall <= perf_stall + 32'd1;
            if (de_flush) perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire
